// File: rtl/pucch_mod_pkg.sv
// pucch_mod_pkg
// Shared definitions for the PUCCH modulation mapper:
//   mod_t    - modulation scheme latched at the start of a codeword
//   state_t  - mapper control state
//   amp(w)   - constellation amplitude round(1/sqrt(2) * 2^(w-1))
package pucch_mod_pkg;

    typedef enum logic [1:0] {
        MOD_BPSK    = 2'd0,
        MOD_PI2BPSK = 2'd1,
        MOD_QPSK    = 2'd2
    } mod_t;

    localparam logic [1:0] MODE_RESERVED = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // 1/sqrt(2) is held as a 9-digit decimal fraction so the amplitude can be
    // elaborated with integer arithmetic only; rounding is half-up.
    function automatic int unsigned amp(input int w);
        longint unsigned scaled;
        scaled = 64'd707106781 << (w - 1);
        return 32'((scaled + 64'd500000000) / 64'd1000000000);
    endfunction

endpackage

// File: rtl/pucch_sym_lut.sv
// pucch_sym_lut
// Combinational constellation lookup for BPSK, pi/2-BPSK and QPSK.
// Ports:
//   b0     - first (or only) bit of the symbol
//   b1     - second bit of the symbol (QPSK only)
//   mode   - modulation scheme
//   parity - LSB of the symbol index; odd symbols are rotated by j in pi/2-BPSK
//   re, im - signed fixed-point symbol components, W-1 fraction bits
module pucch_sym_lut
    import pucch_mod_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         b0,
    input  logic         b1,
    input  mod_t         mode,
    input  logic         parity,
    output logic [W-1:0] re,
    output logic [W-1:0] im
);

    localparam logic signed [W-1:0] POS = W'(amp(W));
    localparam logic signed [W-1:0] NEG = -POS;

    logic signed [W-1:0] pt0;
    logic signed [W-1:0] pt1;

    assign pt0 = b0 ? NEG : POS;
    assign pt1 = b1 ? NEG : POS;

    // BPSK places the bit on the diagonal. Multiplying (v + jv) by j gives
    // (-v + jv), so the pi/2 rotation only has to negate the real part.
    always_comb begin
        re = pt0;
        im = pt0;
        case (mode)
            MOD_PI2BPSK: begin
                if (parity) begin
                    re = -pt0;
                end
            end
            MOD_QPSK: begin
                im = pt1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/pucch_mod_mapper.sv
// pucch_mod_mapper
// Streaming PUCCH modulation mapper: one bit per cycle in, registered complex
// symbols out, with valid/ready on both sides.
// Ports:
//   i_clk, i_rst              - clock, synchronous active-high reset
//   i_start, i_mode           - begin a codeword and select its modulation
//   i_bit, i_bit_valid,
//   i_bit_last, o_bit_ready   - input bit stream handshake
//   o_valid, i_ready          - output symbol handshake
//   o_re, o_im                - symbol components (signed, W-1 fraction bits)
//   o_sym_idx                 - index of the presented symbol within the codeword
//   o_last                    - presented symbol ends the codeword
//   o_err                     - sticky: odd QPSK bit count or reserved mode
module pucch_mod_mapper
    import pucch_mod_pkg::*;
#(
    parameter int W     = 16,
    parameter int IDX_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic             i_bit,
    input  logic             i_bit_valid,
    input  logic             i_bit_last,
    output logic             o_bit_ready,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W-1:0]     o_re,
    output logic [W-1:0]     o_im,
    output logic [IDX_W-1:0] o_sym_idx,
    output logic             o_last,
    output logic             o_err
);

    state_t           state;
    mod_t             mode_q;
    logic             b0_q;
    logic             b0_held;
    logic [IDX_W-1:0] idx_q;

    logic             is_qpsk;
    logic             bit_accept;
    logic             sym_load;
    logic             consume;
    logic             lut_b0;
    logic             lut_b1;
    logic [W-1:0]     lut_re;
    logic [W-1:0]     lut_im;

    // A bit can only enter when the output register is free or draining this
    // cycle; a same-cycle i_start wins over the bit.
    assign o_bit_ready = (state == ST_RUN) && (!o_valid || i_ready);
    assign bit_accept  = o_bit_ready && i_bit_valid && !i_start;
    assign consume     = o_valid && i_ready;
    assign is_qpsk     = (mode_q == MOD_QPSK);

    // QPSK completes a symbol on the second bit, or early when the codeword
    // ends on a first bit (the missing second bit is padded with 0).
    assign sym_load = bit_accept && (!is_qpsk || b0_held || i_bit_last);
    assign lut_b0   = (is_qpsk && b0_held) ? b0_q : i_bit;
    assign lut_b1   = (is_qpsk && b0_held) ? i_bit : 1'b0;

    pucch_sym_lut #(
        .W(W)
    ) u_lut (
        .b0    (lut_b0),
        .b1    (lut_b1),
        .mode  (mode_q),
        .parity(idx_q[0]),
        .re    (lut_re),
        .im    (lut_im)
    );

    // Control FSM, partial-bit register, symbol index and output register.
    // Loading a symbol takes precedence over draining, which gives
    // back-to-back symbols when load and consume coincide. i_start leaves any
    // held output symbol in place so it is still delivered downstream.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            mode_q    <= MOD_BPSK;
            b0_q      <= 1'b0;
            b0_held   <= 1'b0;
            idx_q     <= '0;
            o_valid   <= 1'b0;
            o_re      <= '0;
            o_im      <= '0;
            o_sym_idx <= '0;
            o_last    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            if (sym_load) begin
                o_valid   <= 1'b1;
                o_re      <= lut_re;
                o_im      <= lut_im;
                o_sym_idx <= idx_q;
                o_last    <= i_bit_last;
                idx_q     <= idx_q + IDX_W'(1);
            end else if (consume) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end

            if (i_start) begin
                idx_q   <= '0;
                b0_held <= 1'b0;
                if (i_mode == MODE_RESERVED) begin
                    state <= ST_IDLE;
                    o_err <= 1'b1;
                end else begin
                    state  <= ST_RUN;
                    mode_q <= mod_t'(i_mode);
                    o_err  <= 1'b0;
                end
            end else if (bit_accept) begin
                if (sym_load) begin
                    b0_held <= 1'b0;
                    if (i_bit_last) begin
                        state <= ST_IDLE;
                        if (is_qpsk && !b0_held) begin
                            o_err <= 1'b1;
                        end
                    end
                end else begin
                    b0_q    <= i_bit;
                    b0_held <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pucch_mod_mapper.sv
// tb_pucch_mod_mapper
// Self-checking bench for pucch_mod_mapper: a W=16 and a W=12 instance share
// all inputs. Fixed vectors carry hand-computed constellation points; random
// codewords are checked against a symbol-list model built from the mapping
// rules with plain integer arithmetic.
module tb_pucch_mod_mapper;

    localparam int AMP16 = 23170;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [9:0]  idx;
        logic        last;
    } sym_t;

    typedef struct packed {
        logic [1:0]       mode;
        int               n_bits;
        logic [7:0]       bits;
        int               n_sym;
        logic [3:0][15:0] exp_re;
        logic [3:0][15:0] exp_im;
        logic             exp_err;
    } vec_t;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic [1:0]  i_mode;
    logic        i_bit;
    logic        i_bit_valid;
    logic        i_bit_last;
    logic        i_ready;

    logic        o_bit_ready;
    logic        o_valid;
    logic [15:0] o_re;
    logic [15:0] o_im;
    logic [9:0]  o_sym_idx;
    logic        o_last;
    logic        o_err;

    logic        o_bit_ready_w12;
    logic        o_valid_w12;
    logic [11:0] o_re_w12;
    logic [11:0] o_im_w12;
    logic [9:0]  o_sym_idx_w12;
    logic        o_last_w12;
    logic        o_err_w12;

    int          n_checks;
    int          n_pass;
    bit          rand_ready;
    sym_t        gotq[$];
    sym_t        expq[$];
    logic        exp_err;
    vec_t        vecs[4];

    pucch_mod_mapper #(.W(16), .IDX_W(10)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_mode     (i_mode),
        .i_bit      (i_bit),
        .i_bit_valid(i_bit_valid),
        .i_bit_last (i_bit_last),
        .o_bit_ready(o_bit_ready),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_re       (o_re),
        .o_im       (o_im),
        .o_sym_idx  (o_sym_idx),
        .o_last     (o_last),
        .o_err      (o_err)
    );

    pucch_mod_mapper #(.W(12), .IDX_W(10)) dut_w12 (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_mode     (i_mode),
        .i_bit      (i_bit),
        .i_bit_valid(i_bit_valid),
        .i_bit_last (i_bit_last),
        .o_bit_ready(o_bit_ready_w12),
        .o_valid    (o_valid_w12),
        .i_ready    (i_ready),
        .o_re       (o_re_w12),
        .o_im       (o_im_w12),
        .o_sym_idx  (o_sym_idx_w12),
        .o_last     (o_last_w12),
        .o_err      (o_err_w12)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Records every symbol that the next rising edge will consume.
    initial begin
        forever begin
            @(negedge clk);
            if (!i_rst && o_valid && i_ready) begin
                gotq.push_back({o_re, o_im, o_sym_idx, o_last});
            end
        end
    end

    // Absolute bound on the run time.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no completion, expected finish within 40000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Symbol list from the mapping rules: BPSK point v = b ? -A : A on both
    // axes, j*(v + jv) for odd pi/2-BPSK symbols, bit pairs for QPSK with a
    // zero pad when the count is odd.
    function automatic void model_codeword(input int mode, input bit bits[$]);
        int   n;
        int   n_sym;
        int   a0;
        int   a1;
        int   re;
        int   im;
        bit   b1;
        sym_t e;
        n = bits.size();
        expq.delete();
        n_sym = (mode == 2) ? (n + 1) / 2 : n;
        for (int s = 0; s < n_sym; s++) begin
            if (mode == 2) begin
                b1 = 1'b0;
                if (2 * s + 1 < n) begin
                    b1 = bits[2 * s + 1];
                end
                a0 = bits[2 * s] ? -AMP16 : AMP16;
                a1 = b1 ? -AMP16 : AMP16;
                re = a0;
                im = a1;
            end else begin
                a0 = bits[s] ? -AMP16 : AMP16;
                re = a0;
                im = a0;
                if (mode == 1 && (s % 2) == 1) begin
                    re = -a0;
                end
            end
            e.re   = 16'(re);
            e.im   = 16'(im);
            e.idx  = 10'(s % 1024);
            e.last = (s == n_sym - 1);
            expq.push_back(e);
        end
        exp_err = (mode == 2) && ((n % 2) == 1);
    endfunction

    task automatic start_codeword(input logic [1:0] mode);
        i_start = 1'b1;
        i_mode  = mode;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_mode  = 2'($urandom_range(0, 3));
    endtask

    // Presents one bit and holds it until the mapper accepts it.
    task automatic apply_stimulus(input logic b, input logic last);
        int cyc;
        bit acc;
        cyc         = 0;
        acc         = 1'b0;
        i_bit_valid = 1'b1;
        i_bit       = b;
        i_bit_last  = last;
        while (!acc) begin
            if (rand_ready) begin
                i_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            acc = o_bit_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                cyc++;
                if (cyc > 200) begin
                    n_checks++;
                    $display("[TB] FAIL accept_timeout: got no acceptance, expected one within 200 cycles");
                    acc = 1'b1;
                end
            end
        end
        i_bit_valid = 1'b0;
        i_bit_last  = 1'b0;
        i_bit       = 1'($urandom_range(0, 1));
    endtask

    // Waits until the output register is empty.
    task automatic drain();
        int cyc;
        bit done;
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            if (rand_ready) begin
                i_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            done = !o_valid;
            @(posedge clk);
            #1;
            if (!done) begin
                cyc++;
                if (cyc > 200) begin
                    n_checks++;
                    $display("[TB] FAIL drain_timeout: got o_valid stuck, expected empty within 200 cycles");
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic check_codeword(input string tag, input int base, input int mode,
                                  input bit bits[$]);
        model_codeword(mode, bits);
        check_output({tag, "_count"}, 32'(gotq.size() - base), 32'(expq.size()));
        for (int s = 0; s < expq.size() && base + s < gotq.size(); s++) begin
            check_output({tag, "_re"},   32'(gotq[base + s].re),   32'(expq[s].re));
            check_output({tag, "_im"},   32'(gotq[base + s].im),   32'(expq[s].im));
            check_output({tag, "_idx"},  32'(gotq[base + s].idx),  32'(expq[s].idx));
            check_output({tag, "_last"}, 32'(gotq[base + s].last), 32'(expq[s].last));
        end
        check_output({tag, "_err"}, 32'(o_err), 32'(exp_err));
    endtask

    task automatic set_vec(input int v, input logic [1:0] mode, input int n_bits,
                           input logic [7:0] bits, input int n_sym,
                           input logic [63:0] re, input logic [63:0] im,
                           input logic err);
        vecs[v].mode    = mode;
        vecs[v].n_bits  = n_bits;
        vecs[v].bits    = bits;
        vecs[v].n_sym   = n_sym;
        vecs[v].exp_re  = re;
        vecs[v].exp_im  = im;
        vecs[v].exp_err = err;
    endtask

    initial begin
        int base;
        int mode_r;
        int n_r;
        bit bitsq[$];

        n_checks    = 0;
        n_pass      = 0;
        rand_ready  = 1'b0;
        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_mode      = 2'd0;
        i_bit       = 1'b0;
        i_bit_valid = 1'b0;
        i_bit_last  = 1'b0;
        i_ready     = 1'b1;

        // Expected symbols listed last-first in each 64-bit word.
        set_vec(0, 2'd2, 8, 8'hE4, 4, {16'hA57E, 16'h5A82, 16'hA57E, 16'h5A82},
                {16'hA57E, 16'hA57E, 16'h5A82, 16'h5A82}, 1'b0);
        set_vec(1, 2'd1, 4, 8'h0C, 4, {16'h5A82, 16'hA57E, 16'hA57E, 16'h5A82},
                {16'hA57E, 16'hA57E, 16'h5A82, 16'h5A82}, 1'b0);
        set_vec(2, 2'd0, 2, 8'h02, 2, {32'h0, 16'hA57E, 16'h5A82},
                {32'h0, 16'hA57E, 16'h5A82}, 1'b0);
        set_vec(3, 2'd2, 3, 8'h05, 2, {32'h0, 16'hA57E, 16'hA57E},
                {32'h0, 16'h5A82, 16'h5A82}, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset values");
        check_output("rst_valid",     32'(o_valid),         32'h0);
        check_output("rst_last",      32'(o_last),          32'h0);
        check_output("rst_err",       32'(o_err),           32'h0);
        check_output("rst_re",        32'(o_re),            32'h0);
        check_output("rst_im",        32'(o_im),            32'h0);
        check_output("rst_idx",       32'(o_sym_idx),       32'h0);
        check_output("rst_ready",     32'(o_bit_ready),     32'h0);
        check_output("rst_w12_valid", 32'(o_valid_w12),     32'h0);
        check_output("rst_w12_re",    32'(o_re_w12),        32'h0);
        check_output("rst_w12_im",    32'(o_im_w12),        32'h0);
        check_output("rst_w12_idx",   32'(o_sym_idx_w12),   32'h0);
        check_output("rst_w12_last",  32'(o_last_w12),      32'h0);
        check_output("rst_w12_err",   32'(o_err_w12),       32'h0);
        check_output("rst_w12_ready", 32'(o_bit_ready_w12), 32'h0);
        i_rst = 1'b0;

        $display("[TB] fixed vectors");
        for (int v = 0; v < 4; v++) begin
            base = gotq.size();
            start_codeword(vecs[v].mode);
            for (int i = 0; i < vecs[v].n_bits; i++) begin
                apply_stimulus(vecs[v].bits[i], i == vecs[v].n_bits - 1);
            end
            drain();
            check_output("vec_count", 32'(gotq.size() - base), 32'(vecs[v].n_sym));
            for (int s = 0; s < vecs[v].n_sym && base + s < gotq.size(); s++) begin
                check_output("vec_re",   32'(gotq[base + s].re),   32'(vecs[v].exp_re[s]));
                check_output("vec_im",   32'(gotq[base + s].im),   32'(vecs[v].exp_im[s]));
                check_output("vec_idx",  32'(gotq[base + s].idx),  32'(s));
                check_output("vec_last", 32'(gotq[base + s].last), 32'(s == vecs[v].n_sym - 1));
            end
            check_output("vec_err", 32'(o_err), 32'(vecs[v].exp_err));
        end

        $display("[TB] sticky error and reserved mode");
        repeat (3) @(posedge clk);
        #1;
        check_output("err_sticky",     32'(o_err),       32'h1);
        check_output("idle_ready",     32'(o_bit_ready), 32'h0);
        start_codeword(2'd2);
        check_output("err_cleared",    32'(o_err),       32'h0);
        check_output("run_ready",      32'(o_bit_ready), 32'h1);
        start_codeword(2'd3);
        check_output("err_reserved",   32'(o_err),       32'h1);
        check_output("reserved_ready", 32'(o_bit_ready), 32'h0);
        @(posedge clk);
        #1;
        check_output("reserved_ready_hold", 32'(o_bit_ready), 32'h0);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("err_after_reset", 32'(o_err), 32'h0);
        i_rst = 1'b0;

        $display("[TB] BPSK W=12 latency");
        check_output("w12_idle_valid", 32'(o_valid_w12), 32'h0);
        start_codeword(2'd0);
        apply_stimulus(1'b0, 1'b0);
        check_output("w12_valid0", 32'(o_valid_w12), 32'h1);
        check_output("w12_re0",    32'(o_re_w12),    32'h5A8);
        check_output("w12_im0",    32'(o_im_w12),    32'h5A8);
        apply_stimulus(1'b1, 1'b1);
        check_output("w12_re1",    32'(o_re_w12),    32'hA58);
        check_output("w12_im1",    32'(o_im_w12),    32'hA58);
        check_output("w12_last1",  32'(o_last_w12),  32'h1);
        drain();

        $display("[TB] QPSK backpressure");
        base = gotq.size();
        start_codeword(2'd2);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        i_ready     = 1'b0;
        i_bit_valid = 1'b1;
        i_bit       = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("stall_ready", 32'(o_bit_ready), 32'h0);
            check_output("stall_valid", 32'(o_valid),     32'h1);
            check_output("stall_re",    32'(o_re),        32'hA57E);
            check_output("stall_im",    32'(o_im),        32'h5A82);
            check_output("stall_idx",   32'(o_sym_idx),   32'h0);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1);
        drain();
        bitsq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        check_codeword("stall", base, 2, bitsq);

        $display("[TB] pi/2-BPSK restart");
        start_codeword(2'd1);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        i_ready = 1'b0;
        start_codeword(2'd1);
        check_output("held_valid", 32'(o_valid),   32'h1);
        check_output("held_idx",   32'(o_sym_idx), 32'h2);
        check_output("held_re",    32'(o_re),      32'hA57E);
        i_ready = 1'b1;
        apply_stimulus(1'b0, 1'b1);
        check_output("restart_idx",  32'(o_sym_idx), 32'h0);
        check_output("restart_re",   32'(o_re),      32'h5A82);
        check_output("restart_im",   32'(o_im),      32'h5A82);
        check_output("restart_last", 32'(o_last),    32'h1);
        drain();

        $display("[TB] pi/2-BPSK reset mid-codeword");
        start_codeword(2'd1);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        i_ready = 1'b0;
        i_rst   = 1'b1;
        @(posedge clk);
        #1;
        check_output("mid_rst_valid", 32'(o_valid),     32'h0);
        check_output("mid_rst_re",    32'(o_re),        32'h0);
        check_output("mid_rst_im",    32'(o_im),        32'h0);
        check_output("mid_rst_idx",   32'(o_sym_idx),   32'h0);
        check_output("mid_rst_last",  32'(o_last),      32'h0);
        check_output("mid_rst_err",   32'(o_err),       32'h0);
        check_output("mid_rst_ready", 32'(o_bit_ready), 32'h0);
        i_rst   = 1'b0;
        i_ready = 1'b1;

        $display("[TB] random codewords");
        rand_ready = 1'b1;
        for (int c = 0; c < 31; c++) begin
            mode_r = $urandom_range(0, 2);
            n_r    = $urandom_range(1, 24);
            if (c == 30) begin
                mode_r = 1;
                n_r    = 1030;
            end
            bitsq.delete();
            for (int i = 0; i < n_r; i++) begin
                bitsq.push_back(1'($urandom_range(0, 1)));
            end
            base = gotq.size();
            start_codeword(2'(mode_r));
            for (int i = 0; i < n_r; i++) begin
                apply_stimulus(bitsq[i], i == n_r - 1);
            end
            drain();
            check_codeword("rand", base, mode_r, bitsq);
        end
        rand_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pucch_mod_mapper.md
# pucch_mod_mapper

Streaming, parametrised PUCCH modulation mapper implementing TS 38.211 §5.1 BPSK, π/2-BPSK and QPSK. It supersedes the fixed 16-bit combinational QPSK lookup. The block sits between the PUCCH bit source (scrambler/encoder output) and the resource-element mapper. It accepts one bit per cycle under a valid/ready handshake, tracks the symbol index for π/2 rotation, and emits registered complex symbols with backpressure.

## Interface
- W, 16: output sample width; signed fixed point with W-1 fraction bits.
- IDX_W, 10: symbol index counter width.
- i_clk  in  1  clock; one clock domain.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  begin codeword; latches i_mode, clears index, partial bit and o_err.
- i_mode  in  2  0 BPSK, 1 π/2-BPSK, 2 QPSK, 3 reserved.
- i_bit  in  1  data bit b(i).
- i_bit_valid  in  1  i_bit qualifier.
- i_bit_last  in  1  final bit of the codeword; qualified by i_bit_valid.
- o_bit_ready  out  1  bit accepted when o_bit_ready && i_bit_valid.
- o_valid  out  1  symbol valid.
- i_ready  in  1  downstream ready; symbol consumed when o_valid && i_ready.
- o_re, o_im  out  W  symbol components.
- o_sym_idx  out  IDX_W  index of the presented symbol.
- o_last  out  1  last symbol of the codeword.
- o_err  out  1  sticky error flag: odd QPSK bit count or reserved mode.

## Operation
- Amplitude A = round(0.70710678·2^(W-1)). For W=16, A = 0x5A82 and −A = 0xA57E.
- States:
  - IDLE → RUN on i_start with mode 0/1/2.
  - On i_start with mode 3: set o_err and stay IDLE.
  - RUN → IDLE when the symbol carrying i_bit_last is loaded into the output register.
- i_start is accepted in any state and has priority over a same-cycle bit.
  - A partial QPSK bit is discarded.
  - The held output symbol is kept and is not dropped.
- BPSK: one bit per symbol. re = im = (b ? −A : A).
- π/2-BPSK: one bit per symbol. Start from the BPSK point; if o_sym_idx is odd, multiply by j:
  - new re = −old im
  - new im = old re
- QPSK: two bits per symbol. First accepted bit b0 is held in a register; second bit b1 completes the symbol. re = (b0 ? −A : A), im = (b1 ? −A : A).
- If i_bit_last arrives on b0 in QPSK: b1 is padded as 0, the symbol is emitted with o_last, and o_err is set.
- o_bit_ready = (state==RUN) && (!o_valid || i_ready).
- Index counter:
  - Cleared by i_start.
  - Increments per symbol loaded; wraps modulo 2^IDX_W.
  - Parity uses the LSB, so rotation stays continuous across the wrap.
- Mode is frozen from i_start until the next i_start; i_mode changes in between are ignored.

## Timing
- Reset values:
  - o_valid 0, o_last 0, o_err 0.
  - o_re, o_im, o_sym_idx all 0.
  - o_bit_ready 0; state IDLE.
- Latency: a symbol is on o_* one cycle after its completing bit is accepted.
- Throughput:
  - BPSK/π/2-BPSK: 1 symbol/cycle.
  - QPSK: 1 symbol per 2 cycles.
- While o_valid && !i_ready: o_re, o_im, o_sym_idx and o_last hold stable and no bit is accepted.
- Load and consume in the same cycle is allowed, giving back-to-back symbols.
- o_valid falls the cycle after consumption if no new symbol is loaded.
- i_rst mid-codeword: the next edge returns all outputs to their reset values; any held symbol is lost.

## Structure
- Package pucch_mod_pkg contains:
  - Mode enum: MOD_BPSK, MOD_PI2BPSK, MOD_QPSK.
  - Constant function amp(W).
- Sub-module pucch_sym_lut (combinational) maps (b0, b1, mode, parity) to (re, im).
- The top level holds the FSM, the b0 register, the index counter and the output register.

## Test plan
- QPSK, W=16, bits 00 10 01 11, i_ready=1. Expected (re, im):
  - 0x5A82, 0x5A82
  - 0xA57E, 0x5A82
  - 0x5A82, 0xA57E
  - 0xA57E, 0xA57E
  - o_sym_idx 0..3; o_last on the 4th symbol only.
- π/2-BPSK, bits 0 0 1 1. Expected (re, im):
  - 0x5A82, 0x5A82
  - 0xA57E, 0x5A82
  - 0xA57E, 0xA57E
  - 0x5A82, 0xA57E
- BPSK, W=12, bits 0 1. Expected (re, im): (0x5A8, 0x5A8) then (0xA58, 0xA58). Output appears one cycle after each bit is accepted.
- QPSK with i_ready low for 3 cycles while o_valid=1:
  - Outputs hold stable; o_bit_ready is 0.
  - After release, every input bit appears in order and none are duplicated.
- QPSK with 3 bits 1 0 1 (last on the 3rd):
  - 2nd symbol is (0xA57E, 0x5A82) with o_last.
  - o_err=1 until the next i_start.
  - i_start with mode 3 also sets o_err and leaves o_bit_ready at 0.
- π/2-BPSK, i_start asserted after 3 symbols, then bit 0:
  - The new symbol has idx 0 and value (0x5A82, 0x5A82).
  - Repeat with i_rst instead: all outputs return to reset values.
